// File: rtl/regtrace_pkg.sv
// Shared types and constants for the register-trace monitor: FSM states,
// record framing and architectural register tap indices.
package regtrace_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam int         REC_BYTES   = 5;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;
  localparam int T5 = 5;
  localparam int S0 = 6;
  localparam int S1 = 7;
  localparam int S2 = 8;
  localparam int S3 = 9;
  localparam int A0 = 10;
  localparam int A1 = 11;
  localparam int V0 = 12;
  localparam int RA = 13;

endpackage : regtrace_pkg

// File: rtl/regtrace_change_det.sv
// Per-tap shadow copies and pending flags; a fresh change always beats a
// clear, and changes folded into an already-pending record are counted.
module regtrace_change_det
  import regtrace_pkg::*;
#(
  parameter int NUM_TAPS = 14,
  parameter int W        = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_TAPS*W-1:0]         taps_i,
  input  logic                          clr_valid_i,
  input  logic [3:0]                    clr_idx_i,
  output logic [NUM_TAPS-1:0]           pending_o,
  output logic [NUM_TAPS-1:0][W-1:0]    shadow_o,
  output logic [15:0]                   coalesce_cnt_o
);

  logic [NUM_TAPS-1:0][W-1:0] shadow_q, shadow_d;
  logic [NUM_TAPS-1:0]        pending_q, pending_d;
  logic [15:0]                coal_q, coal_d;
  logic [4:0]                 merge_cnt;
  logic [16:0]                coal_sum;

  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    merge_cnt = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      logic clear;
      clear = clr_valid_i && (clr_idx_i == 4'(i));
      if (taps_i[i*W +: W] != shadow_q[i]) begin
        shadow_d[i]  = taps_i[i*W +: W];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !clear) begin
          merge_cnt = merge_cnt + 5'd1;
        end
      end else if (clear) begin
        pending_d[i] = 1'b0;
      end
    end
    // Several taps may merge in one cycle, so add the whole count and clamp.
    coal_sum = {1'b0, coal_q} + 17'(merge_cnt);
    coal_d   = coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      pending_q <= '0;
      coal_q    <= '0;
    end else begin
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      coal_q    <= coal_d;
    end
  end

  assign pending_o      = pending_q;
  assign shadow_o       = shadow_q;
  assign coalesce_cnt_o = coal_q;

endmodule : regtrace_change_det

// File: rtl/regtrace_monitor.sv
// Serialises register change records (sync/index byte plus 32-bit value,
// MSB first) onto a byte-wide valid/ready stream, lowest index first.
module regtrace_monitor
  import regtrace_pkg::*;
#(
  parameter int NUM_TAPS = 14,
  parameter int W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_TAPS*W-1:0] taps,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [15:0]           coalesce_cnt
);

  logic [NUM_TAPS-1:0]        pending;
  logic [NUM_TAPS-1:0][W-1:0] shadow;
  logic                       clr_valid;
  logic [3:0]                 sel_idx;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic [2:0]  cnt_q, cnt_d;

  regtrace_change_det #(
    .NUM_TAPS(NUM_TAPS),
    .W       (W)
  ) u_change_det (
    .clk           (clk),
    .reset         (reset),
    .taps_i        (taps),
    .clr_valid_i   (clr_valid),
    .clr_idx_i     (sel_idx),
    .pending_o     (pending),
    .shadow_o      (shadow),
    .coalesce_cnt_o(coalesce_cnt)
  );

  // Scan downwards so the lowest pending index is the one left standing.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_TAPS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    val_d     = val_q;
    cnt_d     = cnt_q;
    clr_valid = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          clr_valid = 1'b1;
          idx_d     = sel_idx;
          val_d     = shadow[sel_idx];
          cnt_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        case (cnt_q)
          3'd0:    out_data = {SYNC_NIBBLE, idx_q};
          3'd1:    out_data = val_q[31:24];
          3'd2:    out_data = val_q[23:16];
          3'd3:    out_data = val_q[15:8];
          3'd4:    out_data = val_q[7:0];
          default: out_data = 8'h00;
        endcase
        if (out_ready) begin
          if (cnt_q == 3'(REC_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SEND) || (|pending);

endmodule : regtrace_monitor

// File: tb/tb_regtrace_monitor.sv
// Directed bench for regtrace_monitor: hand-computed record bytes, latency,
// backpressure, coalescing and mid-record reset.
module tb_regtrace_monitor;
  import regtrace_pkg::*;

  localparam int NT = 14;

  logic            clk;
  logic            reset;
  logic [NT*32-1:0] taps;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic [15:0]     coalesce_cnt;

  int checkCount = 0;
  int passCount  = 0;

  regtrace_monitor #(.NUM_TAPS(NT), .W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .taps        (taps),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .coalesce_cnt(coalesce_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int index, input logic [31:0] value);
    taps[index*32 +: 32] = value;
  endtask

  task automatic waitHandshake(input string tag, output bit ok);
    int n = 0;
    while (!(out_valid === 1'b1 && out_ready === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (out_valid === 1'b1) && (out_ready === 1'b1);
    checkOutput({tag, "_arrive"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic expectRecord(input string tag, input logic [3:0] idx,
                              input logic [31:0] val);
    logic [7:0] expBytes [5];
    bit ok;
    expBytes[0] = {4'hA, idx};
    expBytes[1] = val[31:24];
    expBytes[2] = val[23:16];
    expBytes[3] = val[15:8];
    expBytes[4] = val[7:0];
    for (int b = 0; b < 5; b++) begin
      waitHandshake($sformatf("%s_b%0d", tag, b), ok);
      if (!ok) return;
      checkOutput($sformatf("%s_byte%0d", tag, b), {24'b0, out_data}, {24'b0, expBytes[b]});
      @(negedge clk);
    end
  endtask

  initial begin
    int validSeen;
    int busySeen;
    bit ok;

    reset     = 1'b0;
    taps      = '0;
    out_ready = 1'b1;
    $display("[TB] start");

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_data", {24'b0, out_data}, 32'h00);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_coal", {16'b0, coalesce_cnt}, 32'd0);

    reset = 1'b1;
    validSeen = 0;
    busySeen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) validSeen++;
      if (busy !== 1'b0) busySeen++;
    end
    checkOutput("idle_noValid", validSeen, 0);
    checkOutput("idle_noBusy", busySeen, 0);
    checkOutput("idle_coal", {16'b0, coalesce_cnt}, 32'd0);

    // Single change: latency and byte order.
    applyStimulus(T0, 32'h12345678);
    @(negedge clk);
    checkOutput("lat_pendValid", {31'b0, out_valid}, 32'd0);
    checkOutput("lat_pendBusy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("lat_valid", {31'b0, out_valid}, 32'd1);
    expectRecord("t0", 4'd0, 32'h12345678);
    checkOutput("t0_doneValid", {31'b0, out_valid}, 32'd0);
    checkOutput("t0_doneBusy", {31'b0, busy}, 32'd0);

    // Simultaneous changes come out in ascending index order.
    applyStimulus(RA, 32'h00400008);
    applyStimulus(S0, 32'h00000005);
    expectRecord("s0", 4'd6, 32'h00000005);
    checkOutput("gap_idle", {31'b0, out_valid}, 32'd0);
    expectRecord("ra", 4'd13, 32'h00400008);

    // Backpressure on byte 2 holds the byte steady.
    applyStimulus(T2, 32'hCAFEBABE);
    waitHandshake("stall_start", ok);
    checkOutput("stall_b0", {24'b0, out_data}, 32'hA2);
    @(negedge clk);
    checkOutput("stall_b1", {24'b0, out_data}, 32'hCA);
    @(negedge clk);
    checkOutput("stall_b2", {24'b0, out_data}, 32'hFE);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_hold%0d_valid", c), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("stall_hold%0d_data", c), {24'b0, out_data}, 32'hFE);
    end
    out_ready = 1'b1;
    checkOutput("stall_b2_accept", {24'b0, out_data}, 32'hFE);
    @(negedge clk);
    checkOutput("stall_b3", {24'b0, out_data}, 32'hBA);
    @(negedge clk);
    checkOutput("stall_b4", {24'b0, out_data}, 32'hBE);
    @(negedge clk);
    checkOutput("stall_done", {31'b0, out_valid}, 32'd0);

    // Rapid changes to t1 while a t3 record is stuck.
    out_ready = 1'b0;
    applyStimulus(T3, 32'h0000BEEF);
    waitValid("co_t3");
    checkOutput("co_t3_b0", {24'b0, out_data}, 32'hA3);
    applyStimulus(T1, 32'd1);
    @(negedge clk);
    applyStimulus(T1, 32'd2);
    @(negedge clk);
    applyStimulus(T1, 32'd3);
    @(negedge clk);
    @(negedge clk);
    checkOutput("co_count", {16'b0, coalesce_cnt}, 32'd2);
    checkOutput("co_holdData", {24'b0, out_data}, 32'hA3);
    checkOutput("co_busy", {31'b0, busy}, 32'd1);
    out_ready = 1'b1;
    expectRecord("co_t3", 4'd3, 32'h0000BEEF);
    expectRecord("co_t1", 4'd1, 32'h00000003);
    checkOutput("co_countAfter", {16'b0, coalesce_cnt}, 32'd2);

    // Reset in the middle of a record abandons it.
    applyStimulus(T4, 32'h01020304);
    waitHandshake("rr_start", ok);
    checkOutput("rr_b0", {24'b0, out_data}, 32'hA4);
    @(negedge clk);
    checkOutput("rr_b1", {24'b0, out_data}, 32'h01);
    @(negedge clk);
    checkOutput("rr_b2", {24'b0, out_data}, 32'h02);
    @(negedge clk);
    checkOutput("rr_b3", {24'b0, out_data}, 32'h03);
    reset = 1'b0;
    #1;
    checkOutput("rr_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rr_data", {24'b0, out_data}, 32'h00);
    checkOutput("rr_busy", {31'b0, busy}, 32'd0);
    checkOutput("rr_coal", {16'b0, coalesce_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    expectRecord("re_t0", 4'd0, 32'h12345678);
    expectRecord("re_t1", 4'd1, 32'h00000003);
    expectRecord("re_t2", 4'd2, 32'hCAFEBABE);
    expectRecord("re_t3", 4'd3, 32'h0000BEEF);
    expectRecord("re_t4", 4'd4, 32'h01020304);
    expectRecord("re_s0", 4'd6, 32'h00000005);
    expectRecord("re_ra", 4'd13, 32'h00400008);
    @(negedge clk);
    checkOutput("end_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("end_busy", {31'b0, busy}, 32'd0);
    checkOutput("end_coal", {16'b0, coalesce_cnt}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_regtrace_monitor
